// File: rtl/cpu_exec_ctrl_pkg.sv
// Shared types for the CPU execution controller: controller state encoding.
package cpu_exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_STEP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/cpu_exec_ctrl_key_debouncer.sv
// Push-button front end: 2-flop synchronizer, debounce filter and press-duration
// classifier producing one-clk short_evt / long_evt pulses.
module key_debouncer #(
    parameter int debounce_cycles   = 500000,
    parameter int long_press_cycles = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic short_evt,
    output logic long_evt
);

    localparam int w_deb  = $clog2(debounce_cycles + 1);
    localparam int w_hold = $clog2(long_press_cycles + 1);

    localparam logic [w_deb-1:0]  deb_last  = w_deb'(debounce_cycles - 1);
    localparam logic [w_hold-1:0] hold_last = w_hold'(long_press_cycles - 1);
    localparam logic [w_hold-1:0] hold_max  = w_hold'(long_press_cycles);

    logic              sync_0;
    logic              sync_1;
    logic              level;
    logic              level_d;
    logic              long_seen;
    logic [w_deb-1:0]  deb_cnt;
    logic [w_hold-1:0] hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0    <= 1'b0;
            sync_1    <= 1'b0;
            level     <= 1'b0;
            level_d   <= 1'b0;
            long_seen <= 1'b0;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value of its neighbours, which is what makes the synchronizer a
            // real two-stage shift rather than a single wire.
            sync_0    <= key;
            sync_1    <= sync_0;
            level_d   <= level;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;

            // Any sample that agrees with the current level restarts the filter.
            if (sync_1 != level) begin
                if (deb_cnt == deb_last) begin
                    level   <= sync_1;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end

            // Hold counter parks at hold_max so long_evt fires once per press.
            if (level) begin
                if (hold_cnt == hold_last) begin
                    hold_cnt  <= hold_max;
                    long_evt  <= 1'b1;
                    long_seen <= 1'b1;
                end else if (hold_cnt != hold_max) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else begin
                hold_cnt <= '0;
            end

            if (level_d && !level) begin
                short_evt <= !long_seen;
                long_seen <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_exec_ctrl.sv
// Run/pause/single-step/halt controller gating the CPU clock enable from a
// rate strobe and a single push-button, with a saturating executed-cycle count.
module cpu_exec_ctrl
    import cpu_exec_ctrl_pkg::*;
#(
    parameter int debounce_cycles   = 500000,
    parameter int long_press_cycles = 25000000,
    parameter int w_cycle           = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               strobe,
    input  logic               key,
    input  logic               halt_req,
    output logic               cpu_clk_en,
    output state_t             state,
    output logic               halted,
    output logic [w_cycle-1:0] cycle_cnt
);

    logic short_evt;
    logic long_evt;

    key_debouncer #(
        .debounce_cycles  (debounce_cycles),
        .long_press_cycles(long_press_cycles)
    ) u_key_debouncer (
        .clk      (clk),
        .rst      (rst),
        .key      (key),
        .short_evt(short_evt),
        .long_evt (long_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            halted     <= 1'b0;
            cpu_clk_en <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            cpu_clk_en <= 1'b0;

            if (cpu_clk_en && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end

            case (state)
                ST_RUN: begin
                    // halt_req wins over both the strobe and a coincident press.
                    if (halt_req) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end else begin
                        cpu_clk_en <= strobe;
                        if (short_evt) begin
                            state <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (short_evt) begin
                        state <= ST_STEP;
                    end else if (long_evt) begin
                        state <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    cpu_clk_en <= 1'b1;
                    state      <= ST_PAUSE;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_exec_ctrl.sv
// Self-checking bench for cpu_exec_ctrl with short debounce/long-press settings.
module tb_cpu_exec_ctrl;
    import cpu_exec_ctrl_pkg::*;

    localparam int deb_c  = 4;
    localparam int long_c = 20;
    localparam int wc     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          strobe;
    logic          key;
    logic          halt_req;
    logic          cpu_clk_en;
    state_t        state;
    logic          halted;
    logic [wc-1:0] cycle_cnt;

    cpu_exec_ctrl #(
        .debounce_cycles  (deb_c),
        .long_press_cycles(long_c),
        .w_cycle          (wc)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .strobe    (strobe),
        .key       (key),
        .halt_req  (halt_req),
        .cpu_clk_en(cpu_clk_en),
        .state     (state),
        .halted    (halted),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pulse: must appear at a cycle in [due, due+win].
    typedef struct {
        int due;
        int win;
    } pulse_t;
    pulse_t exp_q[$];

    typedef struct {
        int n_strobe;
        int exp_cnt;
    } vec_t;
    vec_t tbl[4];

    int n_cmp  = 0;
    int n_fail = 0;
    int step_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (state == ST_STEP) step_cycles++;
        if (cpu_clk_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected", cyc);
            end else begin
                pulse_t p;
                p = exp_q.pop_front();
                n_cmp++;
                if (cyc < p.due || cyc > p.due + p.win) begin
                    n_fail++;
                    $display("FAIL pulse_time: pulse at cycle %0d, expected %0d..%0d",
                             cyc, p.due, p.due + p.win);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_strobe(input bit expect_pulse);
        strobe = 1'b1;
        if (expect_pulse) exp_q.push_back('{cyc + 1, 0});
        step(1);
        strobe = 1'b0;
        step(9);
    endtask

    task automatic press(input int hold, input bit expect_step);
        key = 1'b1;
        if (expect_step) exp_q.push_back('{cyc, 40});
        step(hold);
        key = 1'b0;
        step(15);
    endtask

    task automatic run_row(input int i);
        repeat (tbl[i].n_strobe) do_strobe(1'b1);
        check($sformatf("row%0d_cnt", i), 32'(cycle_cnt), 32'(tbl[i].exp_cnt));
        check($sformatf("row%0d_state", i), 32'(state), 32'(ST_RUN));
    endtask

    initial begin
        tbl[0] = '{5, 5};
        tbl[1] = '{4, 12};
        tbl[2] = '{4, 15};
        tbl[3] = '{5, 15};

        rst = 1'b1; strobe = 1'b0; key = 1'b0; halt_req = 1'b0;
        step(3);
        check("rst_state", 32'(state), 32'(ST_RUN));
        check("rst_halted", 32'(halted), 0);
        check("rst_en", 32'(cpu_clk_en), 0);
        check("rst_cnt", 32'(cycle_cnt), 0);
        rst = 1'b0;
        step(1);

        run_row(0);

        // Short press in RUN with a strobe landing on the short_evt clk.
        key = 1'b1;
        step(10);
        key = 1'b0;
        step(7);
        strobe = 1'b1;
        exp_q.push_back('{cyc + 1, 0});
        step(1);
        strobe = 1'b0;
        step(10);
        check("short_to_pause", 32'(state), 32'(ST_PAUSE));
        check("coincident_cnt", 32'(cycle_cnt), 6);
        repeat (3) do_strobe(1'b0);
        check("pause_cnt_frozen", 32'(cycle_cnt), 6);
        check("pause_state", 32'(state), 32'(ST_PAUSE));

        for (int k = 0; k < 2; k++) begin
            int s0;
            s0 = step_cycles;
            press(10, 1'b1);
            check($sformatf("step%0d_visits", k), 32'(step_cycles - s0), 1);
            check($sformatf("step%0d_back_pause", k), 32'(state), 32'(ST_PAUSE));
        end
        check("step_cnt", 32'(cycle_cnt), 8);

        key = 1'b1;
        step(30);
        check("long_to_run", 32'(state), 32'(ST_RUN));
        key = 1'b0;
        step(15);
        check("long_release_state", 32'(state), 32'(ST_RUN));
        check("long_cnt", 32'(cycle_cnt), 8);

        repeat (10) begin
            key = 1'b1; step(2);
            key = 1'b0; step(2);
        end
        step(10);
        check("bounce_state", 32'(state), 32'(ST_RUN));

        run_row(1);
        run_row(2);
        run_row(3);

        halt_req = 1'b1;
        strobe   = 1'b1;
        step(1);
        strobe = 1'b0;
        step(2);
        check("halt_state", 32'(state), 32'(ST_HALT));
        check("halt_flag", 32'(halted), 1);
        halt_req = 1'b0;
        press(10, 1'b0);
        press(30, 1'b0);
        do_strobe(1'b0);
        check("halt_sticky", 32'(state), 32'(ST_HALT));
        check("halt_flag_sticky", 32'(halted), 1);

        key = 1'b1;
        step(8);
        rst = 1'b1;
        #1;
        check("midrst_state", 32'(state), 32'(ST_RUN));
        check("midrst_halted", 32'(halted), 0);
        check("midrst_en", 32'(cpu_clk_en), 0);
        check("midrst_cnt", 32'(cycle_cnt), 0);
        step(1);
        rst = 1'b0;
        step(2);
        key = 1'b0;
        step(15);
        check("post_rst_state", 32'(state), 32'(ST_RUN));
        do_strobe(1'b1);
        check("post_rst_cnt", 32'(cycle_cnt), 1);
        check("post_rst_state2", 32'(state), 32'(ST_RUN));

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
